// File: rtl/embedded_system_led_driver_if.sv
// Avalon-MM slave bus bundle for the LED output stage configuration registers.
// Latency: none (plain wires); readdata is combinational in the slave.
// Backpressure: none, zero wait states, no waitrequest.
// Signals: address[1:0], chipselect, write_n, writedata[31:0] (master->slave),
//          readdata[31:0] (slave->master).
interface embedded_system_led_driver_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/embedded_system_led_driver.sv
// LED output stage: PWM dimming plus optional ms-based blinking of the PIO pattern.
// Latency: led_in -> led_out 1 clock; CTRL write -> led_out 2 clocks; DUTY from next pwm wrap.
// Backpressure: none; led_in sampled every clock, register bus has zero wait states.
// Ports: clk, reset_n (async active-low), bus (Avalon-MM slave: CTRL/DUTY/PERIOD/STATUS),
//        led_in[9:0] from the PIO, led_out[9:0] registered LED drive.
// Build option: define LED_DRIVER_BLINK_EN to include the blink logic; otherwise
//        CTRL bit1 and PERIOD read 0 and phase is fixed at 1.
module embedded_system_led_driver #(
  parameter int PWM_DIV = 196,
  parameter int MS_DIV  = 50000
) (
  input  logic                               clk,
  input  logic                               reset_n,
  embedded_system_led_driver_if.slave        bus,
  input  logic [9:0]                         led_in,
  output logic [9:0]                         led_out
);

  localparam int PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam logic [PW-1:0] PWM_LAST = PW'(PWM_DIV - 1);

  logic          wr;
  logic          wr_ctrl;
  logic          wr_duty;
  logic          wr_period;
  logic          enable;
  logic          blink_en;
  logic          phase;
  logic [15:0]   period;
  logic [7:0]    duty_shadow;
  logic [7:0]    duty_act;
  logic [PW-1:0] pwm_pre;
  logic [7:0]    pwm_cnt;
  logic          pwm_tick;
  logic          pwm_wrap;
  logic          lit;
  logic          show;

  assign wr        = bus.chipselect && !bus.write_n;
  assign wr_ctrl   = wr && (bus.address == 2'd0);
  assign wr_duty   = wr && (bus.address == 2'd1);
  assign wr_period = wr && (bus.address == 2'd2);

  logic unused_wdata;
  assign unused_wdata = ^bus.writedata[31:16];

  assign pwm_tick = (pwm_pre == PWM_LAST);
  assign pwm_wrap = pwm_tick && (pwm_cnt == 8'hFF);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable <= 1'b1;
    end else if (wr_ctrl) begin
      enable <= bus.writedata[0];
    end
  end

  // Active duty only changes at the period boundary so a period is never cut short.
  // A DUTY write landing on the wrap cycle is taken directly from the bus.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_pre     <= '0;
      pwm_cnt     <= 8'd0;
      duty_shadow <= 8'hFF;
      duty_act    <= 8'hFF;
    end else begin
      pwm_pre <= pwm_tick ? '0 : pwm_pre + 1'b1;
      if (pwm_tick) begin
        pwm_cnt <= pwm_cnt + 8'd1;
      end
      if (wr_duty) begin
        duty_shadow <= bus.writedata[7:0];
      end
      if (pwm_wrap) begin
        duty_act <= wr_duty ? bus.writedata[7:0] : duty_shadow;
      end
    end
  end

`ifdef LED_DRIVER_BLINK_EN
  localparam int MW = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam logic [MW-1:0] MS_LAST = MW'(MS_DIV - 1);

  logic [MW-1:0] ms_pre;
  logic [15:0]   blink_cnt;
  logic          ms_tick;

  assign ms_tick = (ms_pre == MS_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_en <= 1'b0;
    end else if (wr_ctrl) begin
      blink_en <= bus.writedata[1];
    end
  end

  // A PERIOD write restarts the blink from the start of an on-phase and
  // overrides any ms tick in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period    <= 16'd0;
      ms_pre    <= '0;
      blink_cnt <= 16'd0;
      phase     <= 1'b1;
    end else if (wr_period) begin
      period    <= bus.writedata[15:0];
      ms_pre    <= '0;
      blink_cnt <= 16'd0;
      phase     <= 1'b1;
    end else begin
      ms_pre <= ms_tick ? '0 : ms_pre + 1'b1;
      if (period == 16'd0) begin
        blink_cnt <= 16'd0;
        phase     <= 1'b1;
      end else if (ms_tick) begin
        if (blink_cnt == period - 16'd1) begin
          blink_cnt <= 16'd0;
          phase     <= ~phase;
        end else begin
          blink_cnt <= blink_cnt + 16'd1;
        end
      end
    end
  end
`else
  logic unused_blink;
  assign unused_blink = ^{bus.writedata[15:8], bus.writedata[1], wr_period};
  assign blink_en = 1'b0;
  assign phase    = 1'b1;
  assign period   = 16'd0;
`endif

  assign lit  = (duty_act == 8'hFF) || (pwm_cnt < duty_act);
  assign show = lit & (phase | ~blink_en);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_out <= 10'd0;
    end else begin
      led_out <= enable ? (led_in & {10{show}}) : 10'd0;
    end
  end

  always_comb begin
    bus.readdata = 32'd0;
    case (bus.address)
      2'd0: begin
        bus.readdata[0] = enable;
        bus.readdata[1] = blink_en;
      end
      2'd1: bus.readdata[7:0]  = duty_shadow;
      2'd2: bus.readdata[15:0] = period;
      default: begin
        bus.readdata[0]     = phase;
        bus.readdata[15:8]  = pwm_cnt;
        bus.readdata[25:16] = led_out;
      end
    endcase
  end

endmodule

// File: tb/tb_embedded_system_led_driver.sv
// Directed bench for embedded_system_led_driver with PWM_DIV=1, MS_DIV=4.
// With PWM_DIV=1, pwm_cnt advances every clock, so after n clocks out of reset
// pwm_cnt == n % 256 and the led_out produced at clock n used pwm_cnt (n-1) % 256.
module tb_embedded_system_led_driver;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [9:0] led_in;
  logic [9:0] led_out;

  embedded_system_led_driver_if bus_if ();

  embedded_system_led_driver #(
    .PWM_DIV (1),
    .MS_DIV  (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if),
    .led_in  (led_in),
    .led_out (led_out)
  );

  always #5 clk = ~clk;

  int          n;
  int          passed;
  int          total;
  logic [31:0] rdv;
  int          on_cnt;
  int          bad_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus_if.address    = a;
    bus_if.writedata  = d;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    step();
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus_if.address = a;
    #1;
    d = bus_if.readdata;
  endtask

  // Step until pwm_cnt (as tracked by clock count) equals v; at most 256 clocks.
  task automatic wait_pwm(input int v);
    for (int i = 0; i < 256 && (n % 256) != v; i++) step();
  endtask

  // Run 'cycles' clocks and compare led_out against the PWM expectation each clock.
  task automatic pwm_window(input int duty, input int cycles, input logic [9:0] pat,
                            output int on, output int bad);
    logic lt;
    on  = 0;
    bad = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      lt = (duty == 255) || (((n - 1) % 256) < duty);
      if (led_out !== (lt ? pat : 10'd0)) bad++;
      if (led_out !== 10'd0) on++;
    end
  endtask

  // Blink expectation: k clocks after a PERIOD=3 write, output on for k in 1..12, off 13..24, ...
  task automatic blink_window(input int k_first, input int k_last, output int bad);
    logic [9:0] e;
    bad = 0;
    for (int k = k_first; k <= k_last; k++) begin
      step();
      e = ((((k - 1) / 12) % 2) == 0) ? 10'h001 : 10'h000;
      if (led_out !== e) bad++;
    end
  endtask

  initial begin
    n      = 0;
    passed = 0;
    total  = 0;
    reset_n           = 1'b0;
    led_in            = 10'h2A5;
    bus_if.address    = 2'd0;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.writedata  = 32'd0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    check("reset_led_out", 32'(led_out), 32'd0);
    rd(2'd3, rdv); check("reset_status", rdv, 32'h0000_0001);
    rd(2'd0, rdv); check("reset_ctrl", rdv, 32'h0000_0001);
    rd(2'd1, rdv); check("reset_duty", rdv, 32'h0000_00FF);
    rd(2'd2, rdv); check("reset_period", rdv, 32'h0000_0000);

    // Transparent out of reset, 1 clock latency
    reset_n = 1'b1;
    n = 0;
    step();
    check("first_led_out", 32'(led_out), 32'h2A5);
    rd(2'd3, rdv); check("first_status", rdv, 32'h02A5_0101);
    led_in = 10'h15A;
    #1;
    check("latency_hold", 32'(led_out), 32'h2A5);
    step();
    check("latency_new", 32'(led_out), 32'h15A);

    // Duty shadowing: write 0x80 while pwm_cnt == 0x10, active duty still 0xFF
    led_in = 10'h3FF;
    wait_pwm(16);
    rd(2'd3, rdv); check("status_pwm_cnt", 32'(rdv[15:8]), 32'h10);
    wr(2'd1, 32'h80);
    rd(2'd1, rdv); check("duty_shadow_read", rdv, 32'h80);
    bad_cnt = 0;
    for (int i = 0; i < 256 && (n % 256) != 0; i++) begin
      step();
      if (led_out !== 10'h3FF) bad_cnt++;
    end
    check("shadow_hold_bad", 32'(bad_cnt), 32'd0);
    pwm_window(128, 256, 10'h3FF, on_cnt, bad_cnt);
    check("duty80_on", 32'(on_cnt), 32'd128);
    check("duty80_bad", 32'(bad_cnt), 32'd0);

    // DUTY = 0x40
    wr(2'd1, 32'h40);
    wait_pwm(0);
    pwm_window(64, 256, 10'h3FF, on_cnt, bad_cnt);
    check("duty40_on", 32'(on_cnt), 32'd64);
    check("duty40_bad", 32'(bad_cnt), 32'd0);

    // DUTY = 0 -> never lit
    wr(2'd1, 32'h00);
    wait_pwm(0);
    pwm_window(0, 256, 10'h3FF, on_cnt, bad_cnt);
    check("duty0_on", 32'(on_cnt), 32'd0);

    // DUTY write on the wrap cycle loads at that wrap
    wait_pwm(255);
    wr(2'd1, 32'hFF);
    pwm_window(255, 256, 10'h3FF, on_cnt, bad_cnt);
    check("wrap_write_on", 32'(on_cnt), 32'd256);

    // Disable while lit, counters continue
    wr(2'd0, 32'h0);
    check("disable_edge1", 32'(led_out), 32'h3FF);
    step();
    check("disable_edge2", 32'(led_out), 32'h000);
    repeat (5) step();
    check("disable_hold", 32'(led_out), 32'h000);
    rd(2'd3, rdv);
    check("disable_pwm_cont", 32'(rdv[15:8]), 32'(n % 256));
    check("disable_status_led", 32'(rdv[25:16]), 32'h0);
    wr(2'd0, 32'h1);
    check("enable_edge1", 32'(led_out), 32'h000);
    step();
    check("enable_edge2", 32'(led_out), 32'h3FF);
    rd(2'd3, rdv);
    check("enable_pwm_cont", 32'(rdv[15:8]), 32'(n % 256));

`ifdef LED_DRIVER_BLINK_EN
    // Blink: PERIOD=3 at k=0, CTRL=3 at k=1
    led_in = 10'h001;
    wr(2'd2, 32'd3);
    wr(2'd0, 32'h3);
    blink_window(2, 43, bad_cnt);
    check("blink_bad", 32'(bad_cnt), 32'd0);
    rd(2'd0, rdv); check("blink_ctrl_read", rdv, 32'h3);
    rd(2'd2, rdv); check("blink_period_read", rdv, 32'd3);
    rd(2'd3, rdv); check("blink_phase_off", 32'(rdv[0]), 32'd0);
    // PERIOD rewrite mid-off, coinciding with an ms tick
    wr(2'd2, 32'd3);
    check("restart_edge", 32'(led_out), 32'h000);
    rd(2'd3, rdv); check("restart_phase", 32'(rdv[0]), 32'd1);
    blink_window(1, 30, bad_cnt);
    check("restart_bad", 32'(bad_cnt), 32'd0);
    // PERIOD = 0 holds phase at 1
    wr(2'd2, 32'd0);
    bad_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (i > 0 && led_out !== 10'h001) bad_cnt++;
    end
    check("period0_steady", 32'(bad_cnt), 32'd0);
    wr(2'd0, 32'h1);
`else
    // Blink compiled out: PERIOD and CTRL bit1 read 0, no blinking
    led_in = 10'h001;
    wr(2'd2, 32'd5);
    wr(2'd0, 32'h3);
    rd(2'd2, rdv); check("noblink_period_read", rdv, 32'd0);
    rd(2'd0, rdv); check("noblink_ctrl_read", rdv, 32'h1);
    bad_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (led_out !== 10'h001) bad_cnt++;
    end
    check("noblink_steady", 32'(bad_cnt), 32'd0);
    rd(2'd3, rdv); check("noblink_phase", 32'(rdv[0]), 32'd1);
`endif

    // Asynchronous reset mid-cycle
    wr(2'd1, 32'h33);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_led_out", 32'(led_out), 32'd0);
    rd(2'd3, rdv); check("async_status", rdv, 32'h0000_0001);
    rd(2'd1, rdv); check("async_duty", rdv, 32'hFF);
    rd(2'd0, rdv); check("async_ctrl", rdv, 32'h1);
    step();
    rd(2'd3, rdv); check("reset_held_status", rdv, 32'h0000_0001);
    reset_n = 1'b1;
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
